fetch_queue: RTL

- Instruction-fetch stage directly downstream of the 8-bit program counter register.
- Takes the current PC, issues word-addressed requests to instruction memory with a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO for decode.
- Drives the next-PC value and load strobe back into the PC register.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues word fetches at the current PC over a req/ack
// handshake, buffers {pc, instr} pairs for decode and steers the PC register.
// A redirect flushes the queue. A fetch that is still outstanding when the
// redirect arrives is drained and its data discarded.
module fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned IW       = 32,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    pc_in,
    output logic [7:0]    pc_next,
    output logic          pc_adv,
    output logic          imem_req,
    output logic [7:0]    imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redirect,
    input  logic [7:0]    redirect_pc,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [IW-1:0] dec_instr,
    output logic [7:0]    dec_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [7:0]    drain_addr_q, drain_addr_d;

    logic [7:0]    pc_mem_q    [DEPTH];
    logic [IW-1:0] instr_mem_q [DEPTH];

    logic          pop;
    logic          push;
    logic [CW-1:0] count_eff;

    // Decode side: head presentation and pop; a redirect hides the head.
    always_comb begin
        dec_valid = rst_n && (count_q != '0) && !redirect;
        pop       = dec_valid && dec_ready;
        count_eff = count_q - CW'(pop);
        dec_pc    = pc_mem_q[rd_q];
        dec_instr = instr_mem_q[rd_q];
    end

    // FSM next state plus memory request and PC-register steering.
    always_comb begin
        state_d      = state_q;
        drain_addr_d = drain_addr_q;
        imem_req     = 1'b0;
        imem_addr    = pc_in;
        push         = 1'b0;
        pc_adv       = 1'b0;
        pc_next      = pc_in;
        if (!rst_n) begin
            pc_adv  = 1'b1;
            pc_next = RESET_PC;
        end else begin
            if (state_q == ST_DRAIN) begin
                // Outstanding request is held on its original address; a
                // redirect here keeps the drain going.
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (imem_ack && !redirect) begin
                    state_d = ST_FETCH;
                end
            end else begin
                // Request only while a slot is guaranteed for the response.
                imem_req = (count_eff < CW'(DEPTH));
                push     = imem_req && imem_ack && !redirect;
                if (redirect && imem_req && !imem_ack) begin
                    state_d      = ST_DRAIN;
                    drain_addr_d = pc_in;
                end
            end
            if (redirect) begin
                pc_adv  = 1'b1;
                pc_next = redirect_pc;
            end else if (push) begin
                pc_adv  = 1'b1;
                pc_next = pc_in + 8'd1;
            end
        end
    end

    // Queue occupancy and pointers; a redirect flushes everything.
    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (redirect) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            count_q      <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_q]    <= pc_in;
            instr_mem_q[wr_q] <= imem_rdata;
        end
    end

endmodule
